// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding and FSM states.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULTU = 2'b00,
        MULT  = 2'b01,
        DIVU  = 2'b10,
        DIV   = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Combinational two's-complement negate of d when en is high, pass-through otherwise.
module cond_negate #(
    parameter int N = 32
) (
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    assign q = en ? (~d + N'(1)) : d;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MTHI/MTLO writes.
// Iteration runs on unsigned magnitudes; signs are re-applied in FIN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output muldiv_state_t    state_dbg
);

    // Handshake: start is accepted only in IDLE (never queued); busy is high from the
    // accept edge until the FIN edge; done pulses for the one cycle after FIN, when
    // hi/lo already hold the result and a new start may be accepted.

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t      state;
    muldiv_op_t         op_r;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_b_r;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               is_div;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_cand;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    cond_negate #(.N(WIDTH)) u_neg_a (.en(op[0] & a[WIDTH-1]), .d(a), .q(mag_a));
    cond_negate #(.N(WIDTH)) u_neg_b (.en(op[0] & b[WIDTH-1]), .d(b), .q(mag_b));

    cond_negate #(.N(2*WIDTH)) u_neg_prod (.en(sign_a ^ sign_b), .d(acc), .q(prod_fix));
    cond_negate #(.N(WIDTH)) u_neg_quo (.en(sign_a ^ sign_b), .d(acc[WIDTH-1:0]), .q(quo_fix));
    cond_negate #(.N(WIDTH)) u_neg_rem (.en(sign_a), .d(acc[2*WIDTH-1:WIDTH]), .q(rem_fix));

    assign is_div = (op_r == DIVU) || (op_r == DIV);

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right each step.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b_r : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_cand = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = (div_cand >= {1'b0, mag_b_r});
    assign rem_next = div_ge ? (div_cand[WIDTH-1:0] - mag_b_r) : div_cand[WIDTH-1:0];
    assign div_next = {rem_next, acc[WIDTH-2:0], div_ge};

    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= MULTU;
            cnt      <= '0;
            acc      <= '0;
            mag_b_r  <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wd;
                    if (lo_we) lo <= wd;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        op_r     <= muldiv_op_t'(op);
                        cnt      <= CNT_W'(WIDTH - 1);
                        acc      <= {{WIDTH{1'b0}}, mag_a};
                        mag_b_r  <= mag_b;
                        sign_a   <= op[0] & a[WIDTH-1];
                        sign_b   <= op[0] & b[WIDTH-1];
                        div_zero <= (b == '0);
                    end
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    if (cnt == '0) state <= FIN;
                    else cnt <= cnt - CNT_W'(1);
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
                        // Divide by zero leaves quotient all ones regardless of sign.
                        lo <= div_zero ? {WIDTH{1'b1}} : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: a 32-bit instance for most scenarios and an 8-bit one.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wd = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    muldiv_state_t state_dbg;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        hi_we8 = 1'b0;
    logic        lo_we8 = 1'b0;
    logic [7:0]  wd8 = '0;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;
    muldiv_state_t state_dbg8;

    int total = 0;
    int bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(hi_we8), .lo_we(lo_we8), .wd(wd8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .state_dbg(state_dbg8)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // Scenario tasks
    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_multu;
        int e;
        do_start(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL multu_busy: got %b want 1", busy); end
        wait_done(e);
        total++; if (e != 33) begin bad++; $display("FAIL multu_latency: got %0d want 33", e); end
        total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_end: got %b want 0", busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult_signed;
        int e;
        do_start(MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(e);
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    endtask

    task automatic test_div;
        int e;
        do_start(DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(e);
        total++; if (e != 33) begin bad++; $display("FAIL div_latency: got %0d want 33", e); end
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        do_start(DIVU, 32'hFFFFFFFF, 32'h10);
        wait_done(e);
        total++; if (lo !== 32'h0FFFFFFF) begin bad++; $display("FAIL divu_lo: got %h want 0fffffff", lo); end
        total++; if (hi !== 32'h0000000F) begin bad++; $display("FAIL divu_hi: got %h want 0000000f", hi); end
    endtask

    task automatic test_div_zero;
        int e;
        do_start(DIVU, 32'd7, 32'd0);
        wait_done(e);
        total++; if (e != 33) begin bad++; $display("FAIL div0_latency: got %0d want 33", e); end
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'd7) begin bad++; $display("FAIL divu0_hi: got %h want 00000007", hi); end
        do_start(DIV, 32'hFFFFFFF9, 32'd0);
        wait_done(e);
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'hFFFFFFF9) begin bad++; $display("FAIL div0_hi: got %h want fffffff9", hi); end
    endtask

    task automatic test_overflow;
        int e;
        do_start(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(e);
        total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL ovf_lo: got %h want 80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL ovf_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_start_ignored;
        int e;
        do_start(MULTU, 32'd6, 32'd7);
        e = 0;
        while (done !== 1'b1 && e < 100) begin
            if (e == 4) begin
                start = 1'b1; op = DIV; a = 32'd100; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            e++;
        end
        start = 1'b0;
        total++; if (e != 33) begin bad++; $display("FAIL ign_latency: got %0d want 33", e); end
        total++; if (lo !== 32'd42) begin bad++; $display("FAIL ign_lo: got %h want 0000002a", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL ign_hi: got %h want 00000000", hi); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_not_queued: busy got %b want 0", busy); end
    endtask

    task automatic test_hilo_writes;
        int e;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h12345678;
        @(posedge clk); #1;
        hi_we = 1'b0;
        wd = 32'h9ABCDEF0;
        @(posedge clk); #1;
        lo_we = 1'b0;
        total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mthi_idle: got %h want 12345678", hi); end
        total++; if (lo !== 32'h9ABCDEF0) begin bad++; $display("FAIL mtlo_idle: got %h want 9abcdef0", lo); end
        // MTLO in the same cycle as an accepted start
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3; lo_we = 1'b1; wd = 32'h55555555;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        total++; if (lo !== 32'h55555555) begin bad++; $display("FAIL mtlo_at_start: got %h want 55555555", lo); end
        e = 0;
        while (done !== 1'b1 && e < 100) begin
            hi_we = (e == 3);
            lo_we = (e == 3);
            wd = 32'hDEADBEEF;
            @(posedge clk); #1;
            e++;
            if (e == 4) begin
                total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mthi_busy: got %h want 12345678", hi); end
                total++; if (lo !== 32'h55555555) begin bad++; $display("FAIL mtlo_busy: got %h want 55555555", lo); end
            end
        end
        hi_we = 1'b0; lo_we = 1'b0;
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL hilo_result_hi: got %h want 00000000", hi); end
        total++; if (lo !== 32'd6) begin bad++; $display("FAIL hilo_result_lo: got %h want 00000006", lo); end
    endtask

    task automatic test_back_to_back;
        int e;
        do_start(DIVU, 32'd100, 32'd7);
        wait_done(e);
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL b2b_first_lo: got %h want 0000000e", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL b2b_first_hi: got %h want 00000002", hi); end
        start = 1'b1; op = MULT; a = 32'hFFFFFFFD; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
        wait_done(e);
        total++; if (e != 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", e); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_second_hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL b2b_second_lo: got %h want fffffff1", lo); end
    endtask

    task automatic test_mid_reset;
        int dcount;
        do_start(MULTU, 32'h1234, 32'h10);
        repeat (10) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_running: busy got %b want 1", busy); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL midrst_hi: got %h want 0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL midrst_lo: got %h want 0", lo); end
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL midrst_state: got %0d want IDLE", state_dbg); end
        @(negedge clk) reset = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        total++; if (dcount != 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", dcount); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL midrst_lo_after: got %h want 0", lo); end
    endtask

    task automatic test_width8;
        int e;
        @(negedge clk);
        start8 = 1'b1; op8 = MULT; a8 = 8'h80; b8 = 8'h80;
        @(posedge clk); #1;
        start8 = 1'b0;
        e = 0;
        while (done8 !== 1'b1 && e < 50) begin @(posedge clk); #1; e++; end
        total++; if (e != 9) begin bad++; $display("FAIL w8_latency: got %0d want 9", e); end
        total++; if ({hi8, lo8} !== 16'h4000) begin bad++; $display("FAIL w8_mult: got %h want 4000", {hi8, lo8}); end
        @(negedge clk);
        start8 = 1'b1; op8 = MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        e = 0;
        while (done8 !== 1'b1 && e < 50) begin @(posedge clk); #1; e++; end
        total++; if ({hi8, lo8} !== 16'hFE01) begin bad++; $display("FAIL w8_multu: got %h want fe01", {hi8, lo8}); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_signed();
        test_div();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_hilo_writes();
        test_back_to_back();
        test_mid_reset();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the MIPS core, alongside the single-cycle ALU. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and holds the results in architectural HI/LO registers. It supports direct HI/LO writes for MTHI/MTLO. The core starts an operation with a one-cycle `start` strobe, stalls on `busy`, and reads `hi`/`lo` after `done`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: operation request; sampled only in IDLE.
- `op` in 2: operation select; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in `WIDTH`: multiplicand or dividend (rs).
- `b` in `WIDTH`: multiplier or divisor (rt).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wd` in `WIDTH`: MTHI/MTLO write data.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: single-cycle pulse; `hi`/`lo` hold the new result.
- `hi` out `WIDTH`: HI register. Holds the upper product or the remainder.
- `lo` out `WIDTH`: LO register. Holds the lower product or the quotient.

## Operation
- FSM states: IDLE, RUN, FIN.
  - IDLE with `start`: go to RUN.
  - RUN with count 0: go to FIN.
  - FIN: always go to IDLE.
- Operand capture on start:
  - `a`, `b` and `op` are latched at the accept edge.
  - Later changes on the inputs have no effect on the running operation.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at capture.
  - The operand signs are stored at capture.
  - The iteration always works on unsigned magnitudes.
- Multiply:
  - Radix-2 shift-add over a 2·`WIDTH`-bit accumulator, `WIDTH` iterations.
  - In FIN, the product is negated (2·`WIDTH` bits) if the operand signs differ.
  - Result: `{hi,lo}` = product.
- Divide:
  - Restoring division, `WIDTH` iterations, one quotient bit per cycle.
  - In FIN, the quotient is negated if the signs differ, so it truncates toward zero.
  - In FIN, the remainder takes the sign of the dividend.
  - Result: `lo` = quotient, `hi` = remainder.
- Divide by zero:
  - Takes the same latency as any other divide; no error output.
  - Result for all divide ops: `lo` = all ones, `hi` = `a`.
- Signed overflow (most-negative / −1): `lo` = most-negative value, `hi` = 0. This falls out of the magnitude arithmetic truncated to `WIDTH` bits.
- MTHI/MTLO (`hi_we`, `lo_we`):
  - Honoured only in IDLE; ignored while `busy`.
  - A write in the same cycle as an accepted `start` takes effect. The FIN result later overwrites it.
- `start` outside IDLE is ignored and is not queued.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, iteration counter 0.
- Edge E0: `start` is accepted in IDLE; the FSM enters RUN; `busy` goes to 1 after E0.
- Edges E1…E`WIDTH`: one iteration per edge. The FSM enters FIN after E`WIDTH`.
- Edge E`WIDTH`+1 (the FIN edge) does all of the following:
  - writes `hi`/`lo`;
  - drives `busy` to 0;
  - drives `done` to 1 for exactly one cycle;
  - returns the FSM to IDLE.
- Latency: `WIDTH`+1 edges from accept to result visible. For `WIDTH` = 32 that is 33 edges.
- Back-to-back: `start` during the `done` cycle is accepted (the FSM is in IDLE), so the next operation starts with no bubble.
- `hi`/`lo` are stable except on the FIN edge and on IDLE MTHI/MTLO edges.
- Reset mid-operation:
  - The operation is abandoned and no result is written.
  - All outputs go to their reset values immediately (asynchronous reset).

## Structure
- Package `muldiv_pkg` contains:
  - `muldiv_op_t`, a 2-bit enum: MULTU, MULT, DIVU, DIV;
  - `muldiv_state_t`: IDLE, RUN, FIN.
- Sub-module `cond_negate #(N)`:
  - Combinational two's-complement negate when `en` is high.
  - Reused for operand magnitude conversion, product sign fix and quotient/remainder sign fix.
- The iteration counter is `$clog2(WIDTH)` bits wide and loads `WIDTH`−1 at accept.

## Test plan
All scenarios use `WIDTH` = 32 unless stated.

- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `done` on edge 33; `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- MULT −3 × 5 -> `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1. DIV −7 / 2 -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- Edge cases:
  - DIVU 7 / 0 -> `lo` = 0xFFFFFFFF, `hi` = 7.
  - DIV 0x80000000 / 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0.
- Handshake:
  - `start` pulsed at edge 5 of a running op -> ignored; the result is unchanged.
  - `start` in the `done` cycle -> second result arrives 33 edges later.
  - `hi_we` while `busy` -> `hi` unchanged.
- Reset asserted at iteration 10 -> `busy` = 0, `done` = 0, `hi` = `lo` = 0 immediately. No `done` pulse follows.
- `WIDTH` = 8, MULT 0x80 × 0x80 -> `done` after 9 edges; `{hi,lo}` = 0x4000.
